// File: rtl/phys_reg_freelist_pkg.sv
// Shared rename-stage constants and small helpers for the physical-register
// free list.
//   DISPATCH_WIDTH        lanes per cycle on the pop and push ports
//   PHYS_REGS_ADDR_WIDTH  width of a physical register index
//   ARCH_REGS             indices 0..ARCH_REGS-1 hold the initial arch mapping
package phys_reg_freelist_pkg;

  localparam int unsigned DISPATCH_WIDTH       = 2;
  localparam int unsigned PHYS_REGS_ADDR_WIDTH = 6;
  localparam int unsigned ARCH_REGS            = 32;

  // Wide enough to hold 0..DISPATCH_WIDTH.
  localparam int unsigned LANE_CNT_W = $clog2(DISPATCH_WIDTH + 1);

  typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] preg_t;
  typedef logic [LANE_CNT_W-1:0]           lane_cnt_t;

  function automatic lane_cnt_t popcount(input logic [DISPATCH_WIDTH-1:0] v);
    lane_cnt_t c;
    c = '0;
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      c += lane_cnt_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/phys_reg_freelist_if.sv
// Free-list port bundle between rename (pop), commit (push) and the list.
//   push_reg/push_en  released indices from commit, any lane pattern
//   pop_en            rename consumption, must be a lane-0-first prefix
//   pop_reg           next free indices, lane i = head+i
//   full/empty        list cannot accept / cannot serve a full group
interface freelistIf;
  import phys_reg_freelist_pkg::*;

  preg_t [DISPATCH_WIDTH-1:0] push_reg;
  logic  [DISPATCH_WIDTH-1:0] push_en;
  logic  [DISPATCH_WIDTH-1:0] pop_en;
  preg_t [DISPATCH_WIDTH-1:0] pop_reg;
  logic                       full;
  logic                       empty;

  modport freelist (
    input  push_reg, push_en, pop_en,
    output pop_reg, full, empty
  );

  modport pop (
    output pop_en,
    input  pop_reg, empty
  );

  modport push (
    output push_reg, push_en,
    input  full
  );

endinterface

// File: rtl/phys_reg_freelist_lane_compactor.sv
// Packs enabled push lanes into consecutive write slots.
//   push_en  per-lane push enables, any pattern
//   offset   slot of lane i relative to tail = number of enabled lanes below i
//   npush    total enabled lanes
module lane_compactor
  import phys_reg_freelist_pkg::*;
(
  input  logic      [DISPATCH_WIDTH-1:0] push_en,
  output lane_cnt_t [DISPATCH_WIDTH-1:0] offset,
  output lane_cnt_t                      npush
);

  always_comb begin
    lane_cnt_t acc;
    acc    = '0;
    offset = '0;
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      offset[i] = acc;
      acc       = acc + lane_cnt_t'(push_en[i]);
    end
    npush = acc;
  end

endmodule

// File: rtl/phys_reg_freelist.sv
// Circular free list of physical register indices for the rename stage.
//   clk, rst_n  clock, asynchronous active-low reset
//   fl          freelistIf.freelist: push/pop lanes, full, empty
//   count       number of free indices currently held
// Parameters: DEPTH (power of two), INIT_BASE (first index free at reset).
module phys_reg_freelist
  import phys_reg_freelist_pkg::*;
#(
  parameter int unsigned DEPTH     = 2**PHYS_REGS_ADDR_WIDTH,
  parameter int unsigned INIT_BASE = ARCH_REGS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  freelistIf.freelist            fl,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  preg_t     mem_q [DEPTH];
  preg_t     mem_d [DEPTH];
  ptr_t      head_q, head_d;
  ptr_t      tail_q, tail_d;
  cnt_t      count_q, count_d;
  logic      overflow_q, overflow_d;

  lane_cnt_t [DISPATCH_WIDTH-1:0] push_off;
  lane_cnt_t npush, npush_eff, npop;
  logic      empty, full;

  lane_compactor u_compactor (
    .push_en (fl.push_en),
    .offset  (push_off),
    .npush   (npush)
  );

  // Both flags decode registered count only, so they never follow inputs.
  assign empty    = count_q < cnt_t'(DISPATCH_WIDTH);
  assign full     = count_q > cnt_t'(DEPTH - DISPATCH_WIDTH);
  assign fl.empty = empty;
  assign fl.full  = full;
  assign count    = count_q;

  always_comb begin
    fl.pop_reg = '0;
    for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
      fl.pop_reg[i] = mem_q[head_q + ptr_t'(i)];
    end
  end

  always_comb begin
    mem_d = mem_q;
    // A partial group is never served: while empty, pops are dropped entirely.
    npop      = empty ? '0 : popcount(fl.pop_en);
    npush_eff = full  ? '0 : npush;
    if (!full) begin
      for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
        if (fl.push_en[i]) begin
          mem_d[tail_q + ptr_t'(push_off[i])] = fl.push_reg[i];
        end
      end
    end
    head_d     = head_q + ptr_t'(npop);
    tail_d     = tail_q + ptr_t'(npush_eff);
    count_d    = count_q + cnt_t'(npush_eff) - cnt_t'(npop);
    overflow_d = overflow_q | (full & (|fl.push_en));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        mem_q[k] <= (k < DEPTH - INIT_BASE) ? preg_t'(INIT_BASE + k) : '0;
      end
      head_q     <= '0;
      tail_q     <= ptr_t'(DEPTH - INIT_BASE);
      count_q    <= cnt_t'(DEPTH - INIT_BASE);
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_phys_reg_freelist.sv
module tb_phys_reg_freelist;
  import phys_reg_freelist_pkg::*;

  localparam int DEPTH_T = 64;
  localparam int BASE_T  = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] count;

  freelistIf fl_if ();

  phys_reg_freelist #(.DEPTH(DEPTH_T), .INIT_BASE(BASE_T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fl    (fl_if),
    .count (count)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of free indices plus a sticky overflow.
  int fl_q[$];
  bit m_ovf;

  typedef struct {
    int cnt;
    bit empty;
    bit full;
    bit ovf;
    int p0;
    int p1;
  } exp_t;
  exp_t exp_q[$];

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    fl_q.delete();
    for (int k = BASE_T; k < DEPTH_T; k++) fl_q.push_back(k);
    m_ovf = 1'b0;
  endtask

  // Drive one cycle of stimulus, record the expected pre-edge view, then
  // advance the model across the coming edge.
  task automatic step(input logic [1:0] pe, input logic [1:0] ue,
                      input logic [5:0] r0, input logic [5:0] r1);
    exp_t e;
    int   n;
    @(negedge clk);
    fl_if.pop_en      = pe;
    fl_if.push_en     = ue;
    fl_if.push_reg[0] = r0;
    fl_if.push_reg[1] = r1;
    n       = fl_q.size();
    e.cnt   = n;
    e.empty = (n < 2);
    e.full  = (n > DEPTH_T - 2);
    e.ovf   = m_ovf;
    e.p0    = (n > 0) ? fl_q[0] : -1;
    e.p1    = (n > 1) ? fl_q[1] : -1;
    exp_q.push_back(e);
    if (n >= 2) begin
      for (int i = 0; i < 2; i++) if (pe[i]) void'(fl_q.pop_front());
    end
    if (n > DEPTH_T - 2) begin
      if (ue != 2'b00) m_ovf = 1'b1;
    end else begin
      if (ue[0]) fl_q.push_back(int'(r0));
      if (ue[1]) fl_q.push_back(int'(r1));
    end
  endtask

  function automatic logic [1:0] rand_pop();
    int r;
    r = $urandom_range(0, 2);
    return (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
  endfunction

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", int'(count), e.cnt);
        check("empty", int'(fl_if.empty), int'(e.empty));
        check("full", int'(fl_if.full), int'(e.full));
        check("overflow", int'(dut.overflow_q), int'(e.ovf));
        if (e.p0 >= 0) check("pop_reg0", int'(fl_if.pop_reg[0]), e.p0);
        if (e.p1 >= 0) check("pop_reg1", int'(fl_if.pop_reg[1]), e.p1);
      end
    end
  end

  // Rename must only enable a lane-0-first prefix of pop lanes.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (((fl_if.pop_en + 2'b01) & fl_if.pop_en) == 2'b00)
        else $error("pop_en not a prefix: %b", fl_if.pop_en);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    fl_if.pop_en  = '0;
    fl_if.push_en = '0;
    fl_if.push_reg = '0;
    model_reset();
    #23 rst_n = 1'b1;

    // Reset view.
    step(2'b00, 2'b00, 6'd0, 6'd0);

    // Drain all 32 free indices, then extra pops must be ignored.
    repeat (16) step(2'b11, 2'b00, 6'd0, 6'd0);
    repeat (2) step(2'b11, 2'b00, 6'd0, 6'd0);
    #3;
    // Head now sits on entries never written since reset.
    check("stale_pop0", int'(fl_if.pop_reg[0]), 0);
    check("stale_pop1", int'(fl_if.pop_reg[1]), 0);

    // count=1: single-lane pop ignored; one push brings it to 2.
    step(2'b00, 2'b01, 6'd9, 6'd0);
    step(2'b01, 2'b00, 6'd0, 6'd0);
    step(2'b00, 2'b01, 6'd5, 6'd0);
    step(2'b00, 2'b00, 6'd0, 6'd0);

    // Build to 10, then push lane 1 only alongside a two-lane pop.
    repeat (4) step(2'b00, 2'b11, 6'($urandom), 6'($urandom));
    step(2'b11, 2'b10, 6'd0, 6'd7);
    step(2'b00, 2'b00, 6'd0, 6'd0);

    // Fill to 63 (last accepted push is single-lane at 62), then overflow.
    while (fl_q.size() <= DEPTH_T - 4) step(2'b00, 2'b11, 6'($urandom), 6'($urandom));
    while (fl_q.size() < DEPTH_T - 1) step(2'b00, 2'b01, 6'($urandom), 6'd0);
    step(2'b00, 2'b11, 6'd11, 6'd12);
    step(2'b00, 2'b00, 6'd0, 6'd0);

    // Random traffic, alternating drain-heavy and fill-heavy phases so both
    // boundaries and pointer wrap are crossed many times.
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 300; c++) begin
        logic [1:0] pe, ue;
        pe = rand_pop();
        ue = 2'($urandom);
        if (ph % 2 == 0) begin
          if ($urandom_range(0, 3) != 0) ue = 2'b00;
        end else begin
          if ($urandom_range(0, 3) != 0) pe = 2'b00;
        end
        step(pe, ue, 6'($urandom), 6'($urandom));
      end
    end

    // Asynchronous reset mid-operation: state returns before any clock edge.
    @(negedge clk);
    fl_if.pop_en  = '0;
    fl_if.push_en = '0;
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_count", int'(count), DEPTH_T - BASE_T);
    check("async_rst_empty", int'(fl_if.empty), 0);
    check("async_rst_full", int'(fl_if.full), 0);
    check("async_rst_ovf", int'(dut.overflow_q), 0);
    check("async_rst_pop0", int'(fl_if.pop_reg[0]), BASE_T);
    check("async_rst_pop1", int'(fl_if.pop_reg[1]), BASE_T + 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) step(rand_pop(), 2'($urandom), 6'($urandom), 6'($urandom));

    @(negedge clk);
    fl_if.pop_en  = '0;
    fl_if.push_en = '0;
    #4;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
